// File: rtl/axis_s2mm_stream_arbiter.sv
// axis_s2mm_stream_arbiter: packet-level round-robin merge of NUM_SRC AXI4-Stream sources onto one S2MM stream
`timescale 1ns/1ps
module axis_s2mm_stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int NUM_SRC    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic                          arb_en,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0] src_tkeep,
  input  logic [NUM_SRC-1:0]            src_tvalid,
  input  logic [NUM_SRC-1:0]            src_tlast,
  output logic [NUM_SRC-1:0]            src_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_s2mm_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_s2mm_tkeep,
  output logic                          m_axis_s2mm_tvalid,
  output logic                          m_axis_s2mm_tlast,
  input  logic                          m_axis_s2mm_tready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          beat_cnt,
  output logic [CNT_WIDTH-1:0]          pkt_cnt
);
  localparam int PW = $clog2(NUM_SRC);
  typedef enum logic {IDLE, XFER} state_t;
  state_t               state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d, last_q, last_d, pick, idx;
  logic [CNT_WIDTH-1:0] beat_q, beat_d, pkt_q, pkt_d;
  logic                 found, accept;
  // first valid source after the previous owner, wrapping modulo NUM_SRC
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = PW'((int'(last_q) + k) % NUM_SRC);
      if (!found && src_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  assign busy               = state_q == XFER;
  assign grant              = busy ? NUM_SRC'(1) << gnt_q : '0;
  assign src_tready         = busy ? NUM_SRC'(m_axis_s2mm_tready) << gnt_q : '0;
  assign m_axis_s2mm_tvalid = busy & src_tvalid[gnt_q];
  assign m_axis_s2mm_tlast  = busy & src_tlast[gnt_q];
  assign m_axis_s2mm_tdata  = busy ? src_tdata[gnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_axis_s2mm_tkeep  = busy ? src_tkeep[gnt_q*KEEP_WIDTH +: KEEP_WIDTH] : '0;
  assign accept             = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
  assign beat_cnt           = beat_q;
  assign pkt_cnt            = pkt_q;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    if (state_q == IDLE) begin
      if (arb_en && found) begin
        state_d = XFER;
        gnt_d   = pick;
      end
    end else if (accept) begin
      if (m_axis_s2mm_tlast) begin
        state_d = IDLE;
        last_d  = gnt_q;
        beat_d  = '0;
        pkt_d   = pkt_q + 1'b1;
      end else begin
        beat_d = &beat_q ? beat_q : beat_q + 1'b1;
      end
    end
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= PW'(NUM_SRC-1);
      beat_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
    end
  end
endmodule

// File: tb/tb_axis_s2mm_stream_arbiter.sv
// tb_axis_s2mm_stream_arbiter: directed scenarios plus randomized traffic checked against a packet-level model
`timescale 1ns/1ps
module tb_axis_s2mm_stream_arbiter;
  localparam int DW = 32, KW = 4, N = 4, CW = 16;
  localparam int VW = 2*N + 3 + DW + KW + 2*CW;
  logic clk = 1'b0, rstn = 1'b0, arb_en = 1'b0, m_tready = 1'b0;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready, grant, hs;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tlast, busy;
  logic [CW-1:0]   beat_cnt, pkt_cnt;
  int tests = 0, fails = 0;
  int s_len[N], s_idx[N], s_pkts[N], s_base[N];
  bit s_hold[N];
  int mo = -1, ml = N-1, mb = 0, mp = 0;

  axis_s2mm_stream_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_SRC(N), .CNT_WIDTH(CW)) dut (
    .axi_aclk(clk), .axi_resetn(rstn), .arb_en(arb_en),
    .src_tdata(s_tdata), .src_tkeep(s_tkeep), .src_tvalid(s_tvalid), .src_tlast(s_tlast),
    .src_tready(s_tready),
    .m_axis_s2mm_tdata(m_tdata), .m_axis_s2mm_tkeep(m_tkeep), .m_axis_s2mm_tvalid(m_tvalid),
    .m_axis_s2mm_tlast(m_tlast), .m_axis_s2mm_tready(m_tready),
    .grant(grant), .busy(busy), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) hs = s_tvalid & s_tready;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]          = s_pkts[i] > 0 && !s_hold[i];
      s_tlast[i]           = s_idx[i] == s_len[i] - 1;
      s_tdata[i*DW +: DW]  = DW'(s_base[i] + s_idx[i]);
      s_tkeep[i*KW +: KW]  = KW'(~(s_idx[i] + i));
    end
  endtask

  task automatic set_src(input int i, input int len, input int base, input int pkts);
    s_len[i] = len; s_base[i] = base; s_pkts[i] = pkts; s_idx[i] = 0; s_hold[i] = 1'b0;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) set_src(i, 1, 0, 0);
    drive();
  endtask

  // Advance one clock: the model consumes the inputs seen at the edge, sources advance on real handshakes.
  task automatic tick();
    @(posedge clk);
    if (!rstn) begin
      mo = -1; ml = N-1; mb = 0; mp = 0;
    end else if (mo < 0) begin
      if (arb_en)
        for (int k = 1; k <= N; k++)
          if (mo < 0 && s_tvalid[(ml+k)%N]) mo = (ml+k) % N;
    end else if (s_tvalid[mo] && m_tready) begin
      if (s_tlast[mo]) begin
        ml = mo; mo = -1; mb = 0; mp = (mp + 1) % (1 << CW);
      end else if (mb < (1 << CW) - 1) mb++;
    end
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        s_idx[i]++;
        if (s_idx[i] == s_len[i]) begin
          s_idx[i] = 0; s_pkts[i]--; s_base[i] += 16;
        end
      end
    drive();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_src(i, 2, 32'h10*i, 1);
    rstn = 1'b0; arb_en = 1'b1; m_tready = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid c%0d: got %b want 0", c, m_tvalid); end
      tests++; if (s_tready !== '0) begin fails++; $display("FAIL reset_tready c%0d: got %b want 0", c, s_tready); end
      tests++; if (grant !== '0) begin fails++; $display("FAIL reset_grant c%0d: got %b want 0", c, grant); end
      tests++; if (pkt_cnt !== '0) begin fails++; $display("FAIL reset_pkt c%0d: got %0d want 0", c, pkt_cnt); end
      tick();
    end
    clear_srcs();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_source();
    int n = 0;
    set_src(1, 4, 32'hA0, 1);
    drive();
    @(negedge clk);
    tests++; if (grant !== '0) begin fails++; $display("FAIL single_bubble: grant %b want 0", grant); end
    tick();
    tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL single_grant: grant %b want 0010", grant); end
    for (int c = 0; c < 12 && n < 4; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        tests++; if (m_tdata !== DW'(32'hA0 + n)) begin fails++; $display("FAIL single_data beat%0d: got %h want %h", n, m_tdata, 32'hA0 + n); end
        tests++; if (m_tlast !== (n == 3)) begin fails++; $display("FAIL single_last beat%0d: got %b want %b", n, m_tlast, n == 3); end
        n++;
      end
      tick();
    end
    tests++; if (n != 4) begin fails++; $display("FAIL single_beats: got %0d want 4", n); end
    @(negedge clk);
    tests++; if (pkt_cnt !== CW'(1)) begin fails++; $display("FAIL single_pkt: got %0d want 1", pkt_cnt); end
    tests++; if (grant !== '0) begin fails++; $display("FAIL single_release: grant %b want 0", grant); end
    tick();
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [N-1:0] prev = '0;
    int k = 0;
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 2, 32'h1000*(i+1), 2);
    m_tready = 1'b1; arb_en = 1'b1;
    drive();
    for (int c = 0; c < 100 && pkt_cnt != CW'(5); c++) begin
      @(negedge clk);
      if (grant != '0 && prev == '0) order.push_back($onehot(grant) ? $clog2(grant) : -1);
      if (m_tvalid && m_tready) begin
        tests++; if (m_tlast !== (k == 1)) begin fails++; $display("FAIL rr_contig: tlast %b at beat %0d", m_tlast, k); end
        k = m_tlast ? 0 : k + 1;
      end
      prev = grant;
      tick();
    end
    clear_srcs();
    for (int j = 0; j < 5; j++) begin
      tests++;
      if ((j < order.size() ? order[j] : -2) != j % N) begin
        fails++; $display("FAIL rr_order grant#%0d: got %0d want %0d", j, j < order.size() ? order[j] : -2, j % N);
      end
    end
    tests++; if (pkt_cnt !== CW'(5)) begin fails++; $display("FAIL rr_pkt: got %0d want 5", pkt_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_bc[5] = '{1, 1, 2, 2, 0};
    logic [DW-1:0] got[$];
    set_src(2, 3, 32'hC0, 1);
    m_tready = 1'b1;
    drive();
    tick();
    tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL bp_grant: got %b want 0100", grant); end
    for (int c = 0; c < 5; c++) begin
      m_tready = (c % 2 == 0);
      @(negedge clk);
      if (m_tvalid && m_tready) got.push_back(m_tdata);
      tick();
      tests++; if (beat_cnt !== CW'(exp_bc[c])) begin fails++; $display("FAIL bp_beat_cnt c%0d: got %0d want %0d", c, beat_cnt, exp_bc[c]); end
    end
    m_tready = 1'b1;
    tests++; if (got.size() != 3) begin fails++; $display("FAIL bp_count: got %0d beats want 3", got.size()); end
    for (int j = 0; j < 3 && j < got.size(); j++) begin
      tests++; if (got[j] !== DW'(32'hC0 + j)) begin fails++; $display("FAIL bp_data%0d: got %h want %h", j, got[j], 32'hC0 + j); end
    end
    tests++; if (busy !== 1'b0 || pkt_cnt !== CW'(6)) begin fails++; $display("FAIL bp_end: busy %b pkt %0d want 0/6", busy, pkt_cnt); end
  endtask

  task automatic test_arb_en_drop();
    rstn = 1'b0; tick(); rstn = 1'b1;
    set_src(0, 4, 32'h50, 1);
    set_src(3, 2, 32'h70, 1);
    arb_en = 1'b1; m_tready = 1'b1;
    drive();
    tick();
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL arb_first: got %b want 0001", grant); end
    @(negedge clk); tick();
    arb_en = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin @(negedge clk); tick(); end
    tests++; if (busy !== 1'b0 || pkt_cnt !== CW'(1)) begin fails++; $display("FAIL arb_finish: busy %b pkt %0d want 0/1", busy, pkt_cnt); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (grant !== '0 || m_tvalid !== 1'b0) begin fails++; $display("FAIL arb_hold c%0d: grant %b tvalid %b want 0/0", c, grant, m_tvalid); end
      tick();
    end
    arb_en = 1'b1;
    @(negedge clk);
    tests++; if (grant !== '0) begin fails++; $display("FAIL arb_reenable_bubble: got %b want 0", grant); end
    tick();
    tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL arb_src3: got %b want 1000", grant); end
    for (int c = 0; c < 20 && busy; c++) begin @(negedge clk); tick(); end
    tests++; if (pkt_cnt !== CW'(2)) begin fails++; $display("FAIL arb_drain: pkt %0d want 2", pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    set_src(2, 4, 32'hE0, 1);
    m_tready = 1'b1; arb_en = 1'b1;
    drive();
    tick();
    @(negedge clk); tick();
    rstn = 1'b0;
    @(negedge clk);
    tests++; if (m_tdata !== DW'(32'hE1) || m_tvalid !== 1'b1) begin fails++; $display("FAIL rstmid_beat2: got %h/%b want e1/1", m_tdata, m_tvalid); end
    tick();
    tests++; if (m_tvalid !== 1'b0 || grant !== '0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: tvalid %b grant %b busy %b want 0", m_tvalid, grant, busy); end
    tests++; if (s_tready !== '0 || m_tdata !== '0 || m_tlast !== 1'b0) begin fails++; $display("FAIL rstmid_data: tready %b tdata %h tlast %b want 0", s_tready, m_tdata, m_tlast); end
    tests++; if (beat_cnt !== '0 || pkt_cnt !== '0) begin fails++; $display("FAIL rstmid_cnt: beat %0d pkt %0d want 0/0", beat_cnt, pkt_cnt); end
    set_src(0, 2, 32'h30, 1);
    set_src(2, 2, 32'hE8, 1);
    rstn = 1'b1;
    drive();
    @(negedge clk);
    tests++; if (grant !== '0) begin fails++; $display("FAIL rstmid_bubble: got %b want 0", grant); end
    tick();
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL rstmid_prio: got %b want 0001", grant); end
    for (int c = 0; c < 40 && (s_pkts[0] > 0 || s_pkts[2] > 0); c++) begin @(negedge clk); tick(); end
    tests++; if (pkt_cnt !== CW'(2)) begin fails++; $display("FAIL rstmid_drain: pkt %0d want 2", pkt_cnt); end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp_v, got_v;
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (s_pkts[i] == 0 && $urandom_range(3) == 0)
          set_src(i, 1 + $urandom_range(4), int'($urandom & 32'h00FF_FF00), 1 + $urandom_range(2));
        s_hold[i] = $urandom_range(4) == 0;
      end
      m_tready = $urandom_range(9) < 7;
      arb_en   = $urandom_range(9) != 0;
      rstn     = $urandom_range(299) != 0;
      drive();
      @(negedge clk);
      exp_v = {mo >= 0 ? N'(1) << mo : N'(0), mo >= 0,
               mo >= 0 ? s_tvalid[mo] : 1'b0,
               mo >= 0 ? s_tdata[mo*DW +: DW] : DW'(0),
               mo >= 0 ? s_tkeep[mo*KW +: KW] : KW'(0),
               mo >= 0 ? s_tlast[mo] : 1'b0,
               mo >= 0 && m_tready ? N'(1) << mo : N'(0),
               CW'(mb), CW'(mp)};
      got_v = {grant, busy, m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready, beat_cnt, pkt_cnt};
      tests++;
      if (got_v !== exp_v) begin
        fails++; $display("FAIL random cyc%0d: got %h want %h", cyc, got_v, exp_v);
      end
      tick();
    end
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_src(i, 1, 0, 0);
    drive();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_arb_en_drop();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
